// File: rtl/multdiv_pw_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multdiv_pw_controller: stalls F/D/X and sequences the multdiv unit to P/W |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module multdiv_pw_controller #(
    parameter logic [4:0] OPCODE_ALU = 5'b00000,
    parameter logic [4:0] ALUOP_MUL  = 5'b00110,
    parameter logic [4:0] ALUOP_DIV  = 5'b00111,
    parameter int         TIMEOUT    = 40,
    parameter int         CNT_W      = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] i_x_insn,
    input  logic [31:0] i_md_result,
    input  logic        i_md_rdy,
    input  logic        i_md_exception,
    output logic        o_ctrl_mult,
    output logic        o_ctrl_div,
    output logic        o_stall,
    output logic [31:0] o_insn,
    output logic [31:0] o_result,
    output logic        o_md_rdy,
    output logic        o_exception
);

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_BUSY   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        held_insn_q, held_insn_d;
    logic [31:0]        held_result_q, held_result_d;
    logic               held_exc_q, held_exc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               w_is_md;

    assign w_is_md = (i_x_insn[31:27] == OPCODE_ALU) &&
                     ((i_x_insn[6:2] == ALUOP_MUL) || (i_x_insn[6:2] == ALUOP_DIV));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            held_insn_q   <= '0;
            held_result_q <= '0;
            held_exc_q    <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            held_insn_q   <= held_insn_d;
            held_result_q <= held_result_d;
            held_exc_q    <= held_exc_d;
            cnt_q         <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        held_insn_d   = held_insn_q;
        held_result_d = held_result_q;
        held_exc_d    = held_exc_q;
        cnt_d         = cnt_q;
        o_ctrl_mult   = 1'b0;
        o_ctrl_div    = 1'b0;
        o_stall       = 1'b0;
        o_insn        = '0;
        o_result      = '0;
        o_md_rdy      = 1'b0;
        o_exception   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_is_md) begin
                    o_stall     = 1'b1;
                    held_insn_d = i_x_insn;
                    state_d     = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                // Any ready seen here belongs to the previous operation.
                o_stall     = 1'b1;
                o_ctrl_mult = (held_insn_q[6:2] == ALUOP_MUL);
                o_ctrl_div  = (held_insn_q[6:2] != ALUOP_MUL);
                cnt_d       = '0;
                state_d     = S_BUSY;
            end
            S_BUSY: begin
                o_stall = 1'b1;
                if (i_md_rdy) begin
                    held_result_d = i_md_result;
                    held_exc_d    = i_md_exception;
                    state_d       = S_DONE;
                end else if (cnt_q == C_CNT_LAST) begin
                    held_result_d = '0;
                    held_exc_d    = 1'b1;
                    state_d       = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                // The mul/div in X advances at this edge, so no relaunch.
                o_md_rdy    = 1'b1;
                o_insn      = held_insn_q;
                o_result    = held_result_q;
                o_exception = held_exc_q;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_multdiv_pw_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_multdiv_pw_controller: directed self-checking bench                   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_multdiv_pw_controller;

    localparam logic [31:0] C_MUL1 = 32'h0062_0818;
    localparam logic [31:0] C_MUL2 = 32'h00A6_1018;
    localparam logic [31:0] C_DIV  = 32'h00A4_101C;
    localparam logic [31:0] C_ADD  = 32'h0062_0800;
    localparam logic [31:0] C_NALU = 32'h4000_0018;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] i_x_insn;
    logic [31:0] i_md_result;
    logic        i_md_rdy;
    logic        i_md_exception;
    logic        o_ctrl_mult;
    logic        o_ctrl_div;
    logic        o_stall;
    logic [31:0] o_insn;
    logic [31:0] o_result;
    logic        o_md_rdy;
    logic        o_exception;

    int n_chk  = 0;
    int n_pass = 0;

    multdiv_pw_controller dut (
        .clock          (clock),
        .reset          (reset),
        .i_x_insn       (i_x_insn),
        .i_md_result    (i_md_result),
        .i_md_rdy       (i_md_rdy),
        .i_md_exception (i_md_exception),
        .o_ctrl_mult    (o_ctrl_mult),
        .o_ctrl_div     (o_ctrl_div),
        .o_stall        (o_stall),
        .o_insn         (o_insn),
        .o_result       (o_result),
        .o_md_rdy       (o_md_rdy),
        .o_exception    (o_exception)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic nxt();
        @(posedge clock);
        #1;
    endtask

    task automatic smp();
        @(negedge clock);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {29'd0, o_ctrl_mult, o_ctrl_div, o_stall}, 32'd0);
        chk({tag, "_rdy"}, {30'd0, o_md_rdy, o_exception}, 32'd0);
        chk({tag, "_insn"}, o_insn, 32'd0);
        chk({tag, "_res"}, o_result, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int done_k;
        int stall_cnt;
        logic [31:0] to_res;
        logic        to_exc;

        reset = 1'b1; i_x_insn = '0; i_md_result = '0;
        i_md_rdy = 1'b0; i_md_exception = 1'b0;
        nxt(); nxt();
        smp(); chk_all_zero("reset");
        nxt(); reset = 1'b0;

        // Mul with result at T+4
        i_x_insn = C_MUL1;
        smp(); chk("mul_T_stall", o_stall, 1); chk("mul_T_pulse", o_ctrl_mult, 0);
        nxt();
        smp(); chk("mul_T1_mult", o_ctrl_mult, 1); chk("mul_T1_div", o_ctrl_div, 0);
        chk("mul_T1_stall", o_stall, 1);
        nxt();
        smp(); chk("mul_T2_mult", o_ctrl_mult, 0); chk("mul_T2_stall", o_stall, 1);
        nxt();
        nxt(); i_md_rdy = 1'b1; i_md_result = 32'h0000_002A;
        smp(); chk("mul_T4_rdy", o_md_rdy, 0); chk("mul_T4_stall", o_stall, 1);
        nxt(); i_md_rdy = 1'b0; i_md_result = '0;
        smp(); chk("mul_T5_rdy", o_md_rdy, 1); chk("mul_T5_res", o_result, 32'h2A);
        chk("mul_T5_insn", o_insn, C_MUL1); chk("mul_T5_stall", o_stall, 0);
        chk("mul_T5_exc", o_exception, 0);
        nxt(); i_x_insn = '0;
        smp(); chk_all_zero("mul_T6");

        // Div with exception
        nxt(); i_x_insn = C_DIV;
        nxt();
        smp(); chk("div_T1_div", o_ctrl_div, 1); chk("div_T1_mult", o_ctrl_mult, 0);
        nxt();
        nxt(); i_md_rdy = 1'b1; i_md_exception = 1'b1; i_md_result = 32'hFFFF_FFFF;
        nxt(); i_md_rdy = 1'b0; i_md_exception = 1'b0; i_md_result = '0;
        smp(); chk("div_rdy", o_md_rdy, 1); chk("div_exc", o_exception, 1);
        chk("div_res", o_result, 32'hFFFF_FFFF); chk("div_insn", o_insn, C_DIV);
        nxt(); i_x_insn = '0;

        // Stale ready held from T through T+2
        nxt(); i_x_insn = C_MUL1; i_md_rdy = 1'b1; i_md_result = 32'h0000_0055;
        nxt();
        smp(); chk("stale_T1_rdy", o_md_rdy, 0);
        nxt();
        smp(); chk("stale_T2_rdy", o_md_rdy, 0);
        nxt(); i_md_rdy = 1'b0; i_md_result = '0;
        smp(); chk("stale_T3_rdy", o_md_rdy, 1); chk("stale_T3_res", o_result, 32'h55);
        nxt(); i_x_insn = '0;

        // Timeout: no ready ever
        nxt(); i_x_insn = C_DIV;
        done_k = 999; stall_cnt = 0; to_res = 32'hDEAD_BEEF; to_exc = 1'b0;
        for (int k = 0; k < 60 && done_k == 999; k++) begin
            smp();
            if (o_md_rdy) begin
                done_k = k; to_res = o_result; to_exc = o_exception;
            end else if (o_stall) begin
                stall_cnt++;
            end
            nxt();
        end
        i_x_insn = '0;
        chk("tmo_cycle", done_k, 42);
        chk("tmo_stall_cycles", stall_cnt, 42);
        chk("tmo_res", to_res, 0);
        chk("tmo_exc", to_exc, 1);

        // Reset mid-BUSY
        nxt(); i_x_insn = C_MUL1;
        nxt();
        nxt();
        nxt(); reset = 1'b1; i_x_insn = '0;
        smp(); chk("rst_T3_stall", o_stall, 1);
        nxt(); reset = 1'b0;
        smp(); chk_all_zero("rst_T4");
        nxt(); i_md_rdy = 1'b1; i_md_result = 32'h77;
        smp(); chk("rst_T5_rdy", o_md_rdy, 0);
        nxt(); i_md_rdy = 1'b0; i_md_result = '0;
        smp(); chk("rst_T6_rdy", o_md_rdy, 0); chk("rst_T6_ctl", {o_ctrl_mult, o_ctrl_div}, 0);

        // Non-md instructions
        nxt(); i_x_insn = C_ADD;
        smp(); chk("add_T0", {o_ctrl_mult, o_ctrl_div, o_stall}, 0);
        nxt();
        smp(); chk("add_T1", {o_ctrl_mult, o_ctrl_div, o_stall}, 0);
        nxt(); i_x_insn = C_NALU;
        smp(); chk("nalu_T0", {o_ctrl_mult, o_ctrl_div, o_stall}, 0);
        nxt();
        smp(); chk("nalu_T1", {o_ctrl_mult, o_ctrl_div, o_stall}, 0);

        // Back-to-back muls
        nxt(); i_x_insn = C_MUL1;
        nxt();
        nxt(); i_md_rdy = 1'b1; i_md_result = 32'h1;
        nxt(); i_md_rdy = 1'b0; i_md_result = '0;
        smp(); chk("b2b_done1", o_md_rdy, 1); chk("b2b_res1", o_result, 32'h1);
        nxt(); i_x_insn = C_MUL2;
        smp(); chk("b2b_idle_stall", o_stall, 1); chk("b2b_idle_mult", o_ctrl_mult, 0);
        chk("b2b_idle_rdy", o_md_rdy, 0);
        nxt();
        smp(); chk("b2b_launch2", o_ctrl_mult, 1);
        nxt(); i_md_rdy = 1'b1; i_md_result = 32'h2;
        nxt(); i_md_rdy = 1'b0; i_md_result = '0;
        smp(); chk("b2b_done2", o_md_rdy, 1); chk("b2b_res2", o_result, 32'h2);
        chk("b2b_insn2", o_insn, C_MUL2);
        nxt(); i_x_insn = '0;
        smp(); chk_all_zero("b2b_end");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
